avalon_ram_agent: RTL
=====================

# avalon_ram_agent

Avalon-MM agent (responder) that answers the CPU's memory-host accesses: a word-organised RAM with byte-enabled writes and pipelined reads at a fixed, parameterised latency. It sits on the far end of the CPU's data port, or its instruction port with writes tied off, and replaces ad-hoc stimulus with a real memory model usable both in synthesis and in CPU benches. After reset it zero-fills its storage while holding `waitrequest` high.

## Interface
- `DEPTH`, 1024: number of 32-bit words. Must be a power of two, ≥2.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`. Must be ≥1.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `address` in 32: byte address. Bits [1:0] are ignored.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data (`word`).
- `byteenable` in 4: per-byte write enable; bit i controls byte lane i.
- `waitrequest` out 1: request is not accepted this cycle.
- `readdata` out 32: read data, meaningful only while `readdatavalid` is high.
- `readdatavalid` out 1: `readdata` carries a response.

## Operation
- States: INIT and READY.
- INIT:
  - Entered on any cycle where `rst` is high.
  - A clear counter writes 0 to word 0..DEPTH-1, one word per cycle.
  - `waitrequest` is held at 1.
  - `read` and `write` are ignored.
- INIT → READY after the write to word DEPTH-1. READY persists until `rst` is high.
- Acceptance: a request is accepted when the FSM is in READY, `waitrequest` is 0, and `read` or `write` is 1.
- Word index is `address[$clog2(DEPTH)+1:2]`. The address is out of range when any bit of `address[31:$clog2(DEPTH)+2]` is set.
- Write:
  - Commits at the acceptance edge, updating only the enabled bytes.
  - `byteenable`=0 is a legal no-op.
  - Out-of-range writes are dropped.
- Read:
  - Memory is sampled at the acceptance edge.
  - The result travels down a READ_LATENCY-deep valid/data pipeline.
  - Out-of-range reads return 0, still with `readdatavalid`.
- `read` and `write` both high is a protocol violation. The write is performed, the read is discarded, and no response is produced.
- Responses return strictly in request order. With one read accepted per cycle, throughput is 1 read/cycle.
- `waitrequest` is high exactly when the FSM is in INIT.

## Timing
- Reset values, on the cycle after `rst` is sampled high:
  - `waitrequest`=1, `readdatavalid`=0, `readdata`=0.
  - Read pipeline flushed.
  - Clear counter=0.
- `rst` deasserted before edge E: `waitrequest` falls after edge E+DEPTH-1, i.e. DEPTH cycles of INIT.
- Read latency: a read accepted at edge N gives `readdatavalid`=1 with data in the cycle following edge N+READ_LATENCY-1. For READ_LATENCY=1 the response comes in the very next cycle.
- Read-after-write:
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - Data already in flight is not altered by later writes.
- `readdata` holds its last value while `readdatavalid`=0. Benches must not check it then.
- Reset mid-operation:
  - All in-flight reads are discarded; `readdatavalid`=0 from the next cycle.
  - The memory is re-cleared and INIT restarts from word 0.
  - Pending writes at the reset edge are not performed.
- Clear-counter wrap: the counter stops at DEPTH-1. It must not overflow into a second clear pass.

## Structure
- `agent_state_t` (INIT, READY) goes in the shared `Types` package. `word` is reused from that package for data.
- Sub-module `read_latency_pipe` holds a DEPTH-agnostic shift pipeline of {valid, word}, parameterised by READ_LATENCY, with a synchronous flush. It is reusable by other agents.
- Storage is an inferred RAM with per-byte write enables. The INIT clear drives the same write port through a mux.
- A thin wrapper binds the flat ports to the `AvalonMmRw` (and `AvalonMmRead`) agent-side modport. The wrapper contains no logic.

## Test plan
- **Reset/init.** DEPTH=16: pulse `rst` 1 cycle → `waitrequest`=1 for exactly 16 cycles, then 0. A read of 0x3C then returns 0.
- **Byte-enable write.** Write 0xDEADBEEF to 0x8 with be=4'b1111, then 0x00AA0000 with be=4'b0100, then read 0x8 → 0xDEAABEEF exactly READ_LATENCY cycles after acceptance.
- **Pipelined reads.** READ_LATENCY=3: pre-load words 0..3 with 10, 11, 12, 13 and issue back-to-back reads of 0x0, 0x4, 0x8, 0xC → `readdatavalid` high 4 consecutive cycles starting 3 cycles after the first acceptance, with data 10, 11, 12, 13.
- **Read-after-write and out-of-range.** Write 7 to 0x4 at edge N and read 0x4 at edge N+1 → 7. Read 0x1000 with DEPTH=16 → 0 with `readdatavalid`. Write to 0x1000 → no word changes.
- **Reset mid-flight.** READ_LATENCY=3: issue 2 reads, assert `rst` 1 cycle later → no `readdatavalid` ever appears for them, `waitrequest` is re-asserted, and memory reads 0 after INIT.
- **Protocol violation.** `read`=`write`=1 with 0x5 at 0x0 → 0x0 becomes 5 and no response appears.

Source files
------------

// File: rtl/avalon_ram_agent_pkg.sv
// avalon_ram_agent_pkg: shared data word and agent state types
package avalon_ram_agent_pkg;
  typedef logic [31:0] word;
  typedef enum logic {INIT, READY} agent_state_t;
endpackage

// File: rtl/read_latency_pipe.sv
// read_latency_pipe: fixed-depth {valid, word} shift pipeline with synchronous flush
module read_latency_pipe
  import avalon_ram_agent_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic flush_i,
  input  logic valid_i,
  input  word  data_i,
  output logic valid_o,
  output word  data_o
);
  logic [LAT-1:0] v_q, v_d;
  word d_q [LAT];
  word d_d [LAT];
  assign v_d[0] = valid_i;
  assign d_d[0] = data_i;
  for (genvar i = 1; i < LAT; i++) begin : g_stage
    assign v_d[i] = v_q[i-1];
    assign d_d[i] = d_q[i-1];
  end
  // shift valids every cycle; data only moves with a valid so the output holds between responses
  always_ff @(posedge clk) begin
    for (int k = 0; k < LAT; k++) begin
      v_q[k] <= flush_i ? 1'b0 : v_d[k];
      d_q[k] <= flush_i ? '0 : (v_d[k] ? d_d[k] : d_q[k]);
    end
  end
  assign valid_o = v_q[LAT-1];
  assign data_o  = d_q[LAT-1];
endmodule

// File: rtl/avalon_ram_agent.sv
// avalon_ram_agent: Avalon-MM RAM responder with byte-enabled writes, pipelined reads and clear-on-reset
module avalon_ram_agent
  import avalon_ram_agent_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  word         writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output word         readdata,
  output logic        readdatavalid
);
  localparam int AW = $clog2(DEPTH);
  agent_state_t state_q, state_d;
  logic [AW-1:0] clr_q, clr_d, idx, widx;
  logic [3:0] wbe;
  logic init, oor, wen, rd_acc, unused_addr;
  word wdata, rdata;
  word mem [DEPTH];
  assign init        = state_q == INIT;
  assign idx         = address[AW+1:2];
  assign oor         = |address[31:AW+2];
  assign unused_addr = ^address[1:0];
  assign waitrequest = init;
  assign rd_acc      = !init && read && !write;
  assign wen         = !rst && (init || (write && !oor));
  assign widx        = init ? clr_q : idx;
  assign wbe         = init ? 4'hF : byteenable;
  assign wdata       = init ? '0 : writedata;
  assign rdata       = oor ? '0 : mem[idx];
  // clear sweep: advance one word per cycle, stop on the last word and go READY
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (init) begin
      state_d = clr_q == AW'(DEPTH - 1) ? READY : INIT;
      clr_d   = clr_q == AW'(DEPTH - 1) ? clr_q : clr_q + AW'(1);
    end
  end
  // state and clear counter registers
  always_ff @(posedge clk) begin
    state_q <= rst ? INIT : state_d;
    clr_q   <= rst ? '0 : clr_d;
  end
  // single write port shared by the clear sweep and host writes
  always_ff @(posedge clk) begin
    if (wen)
      for (int b = 0; b < 4; b++)
        if (wbe[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
  end
  read_latency_pipe #(.LAT(READ_LATENCY)) u_pipe (
    .clk     (clk),
    .flush_i (rst),
    .valid_i (rd_acc),
    .data_i  (rdata),
    .valid_o (readdatavalid),
    .data_o  (readdata)
  );
endmodule
